// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, exception cause codes and writeback sequencer states.
// Pure declarations, no logic; imported by the ALU and the stages around it.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_DIV   = 4'h8;
    localparam logic [3:0] OP_ANDI  = 4'hC;
    localparam logic [3:0] OP_ORI   = 4'hE;
    localparam logic [3:0] OP_ADDNF = 4'hF;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_DIV0 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB1  = 2'd1,
        ST_WB2  = 2'd2,
        ST_EXC  = 2'd3
    } wb_state_t;

    // MUL and DIV produce a second word that goes to R0 after the Rd write.
    function automatic logic is_dual(input logic [3:0] ctrl);
        return (ctrl == OP_MUL) || (ctrl == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_wb_seq.sv
// ALU writeback sequencer: Rd write 1 cycle after transfer, R0 write 2 cycles after for MUL/DIV.
// Backpressure: in_ready low in WB2, EXC, WB1 of a MUL/DIV, and while reset is low.
module alu_wb_seq
    import alu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int R0_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] alu_r0,
    input  logic          alu_ovf,
    input  logic          alu_b_zero,
    input  logic [AW-1:0] in_rd,
    input  logic          in_wb_en,
    input  logic [DW-1:0] in_pc,
    input  logic          flush,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          exc_valid,
    output logic [1:0]    exc_cause,
    output logic [DW-1:0] exc_pc,
    input  logic          exc_ack
);

    wb_state_t     r_state;
    wb_state_t     w_nxt_state;

    logic          r_dual;
    logic          r_div0;
    logic [DW-1:0] r_out;
    logic [DW-1:0] r_r0;
    logic [AW-1:0] r_rd;
    logic          r_wb_en;
    logic [DW-1:0] r_pc;

    logic          w_in_div0;
    logic          w_in_fault;
    logic          w_offer;
    logic          w_load;

    assign w_in_div0  = (alu_ctrl == OP_DIV) && alu_b_zero;
    assign w_in_fault = w_in_div0 || alu_ovf;
    // A transfer presented together with flush is consumed but discarded.
    assign w_offer    = in_valid && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dual  <= 1'b0;
            r_div0  <= 1'b0;
            r_out   <= '0;
            r_r0    <= '0;
            r_rd    <= '0;
            r_wb_en <= 1'b0;
            r_pc    <= '0;
        end else if (w_load) begin
            r_dual  <= is_dual(alu_ctrl);
            r_div0  <= w_in_div0;
            r_out   <= alu_out;
            r_r0    <= alu_r0;
            r_rd    <= in_rd;
            r_wb_en <= in_wb_en;
            r_pc    <= in_pc;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        in_ready    = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        exc_valid   = 1'b0;
        exc_cause   = EXC_NONE;
        exc_pc      = '0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_offer) begin
                    w_load      = 1'b1;
                    w_nxt_state = w_in_fault ? ST_EXC : ST_WB1;
                end
            end
            ST_WB1: begin
                in_ready = !r_dual;
                rf_we    = r_wb_en;
                rf_waddr = r_rd;
                rf_wdata = r_out;
                if (flush) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_dual) begin
                    w_nxt_state = ST_WB2;
                end else if (in_valid) begin
                    w_load      = 1'b1;
                    w_nxt_state = w_in_fault ? ST_EXC : ST_WB1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WB2: begin
                rf_we       = 1'b1;
                rf_waddr    = AW'(R0_ADDR);
                rf_wdata    = r_r0;
                w_nxt_state = ST_IDLE;
            end
            ST_EXC: begin
                exc_valid = 1'b1;
                exc_cause = r_div0 ? EXC_DIV0 : EXC_OVF;
                exc_pc    = r_pc;
                if (exc_ack) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // Flush kills the write in the same cycle; EXC outputs are deliberately left alone.
        if (flush) begin
            rf_we = 1'b0;
        end

        // Outputs hold their reset values for as long as reset is asserted, not just after the edge.
        if (!reset) begin
            w_load    = 1'b0;
            in_ready  = 1'b0;
            rf_we     = 1'b0;
            rf_waddr  = '0;
            rf_wdata  = '0;
            exc_valid = 1'b0;
            exc_cause = EXC_NONE;
            exc_pc    = '0;
        end
    end

endmodule

// File: tb/tb_alu_wb_seq.sv
// Self-checking bench for alu_wb_seq: expected RF writes are queued at drive time and matched on the write port.
module tb_alu_wb_seq;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] alu_r0;
    logic          alu_ovf;
    logic          alu_b_zero;
    logic [AW-1:0] in_rd;
    logic          in_wb_en;
    logic [DW-1:0] in_pc;
    logic          flush;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          exc_valid;
    logic [1:0]    exc_cause;
    logic [DW-1:0] exc_pc;
    logic          exc_ack;

    always #5 clk = ~clk;

    alu_wb_seq #(.DW(DW), .AW(AW), .R0_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_r0     (alu_r0),
        .alu_ovf    (alu_ovf),
        .alu_b_zero (alu_b_zero),
        .in_rd      (in_rd),
        .in_wb_en   (in_wb_en),
        .in_pc      (in_pc),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .exc_ack    (exc_ack)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    logic [3:0] b2b_ops [3] = '{OP_ADD, OP_SUB, OP_ORI};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one ALU result for a single cycle; queues the writes it should produce.
    task automatic send(input logic [3:0] ctrl, input logic [DW-1:0] out, input logic [DW-1:0] r0,
                        input logic ovf, input logic bz, input logic [AW-1:0] rd, input logic wb,
                        input logic [DW-1:0] pc, input logic fl, input bit keep_r0);
        in_valid   = 1'b1;
        alu_ctrl   = ctrl;
        alu_out    = out;
        alu_r0     = r0;
        alu_ovf    = ovf;
        alu_b_zero = bz;
        in_rd      = rd;
        in_wb_en   = wb;
        in_pc      = pc;
        flush      = fl;
        chk("send_in_ready", 32'(in_ready), 32'd1);
        if (!fl && !ovf && !(ctrl == OP_DIV && bz)) begin
            if (wb) exp_q.push_back('{cyc + 1, rd, out});
            if ((ctrl == OP_MUL || ctrl == OP_DIV) && keep_r0) exp_q.push_back('{cyc + 2, 4'd0, r0});
        end
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("wr_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("wr_addr", 32'(rf_waddr), 32'(mon_e.addr));
                chk("wr_data", 32'(rf_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rf_we"},     32'(rf_we),     32'd0);
        chk({tag, "_rf_waddr"},  32'(rf_waddr),  32'd0);
        chk({tag, "_rf_wdata"},  32'(rf_wdata),  32'd0);
        chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, "_exc_cause"}, 32'(exc_cause), 32'd0);
        chk({tag, "_exc_pc"},    32'(exc_pc),    32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        alu_ctrl   = '0;
        alu_out    = '0;
        alu_r0     = '0;
        alu_ovf    = 1'b0;
        alu_b_zero = 1'b0;
        in_rd      = '0;
        in_wb_en   = 1'b0;
        in_pc      = '0;
        flush      = 1'b0;
        exc_ack    = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD: single write next cycle, ready stays high
        send(OP_ADD, 16'h0005, 16'h0000, 1'b0, 1'b0, 4'd3, 1'b1, 16'h0010, 1'b0, 1'b1);
        chk("add_wb1_ready", 32'(in_ready), 32'd1);
        tick();

        // MUL: Rd then R0, ready low for both writes
        send(OP_MUL, 16'h2000, 16'h0001, 1'b0, 1'b0, 4'd5, 1'b1, 16'h0020, 1'b0, 1'b1);
        chk("mul_wb1_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mul_wb2_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mul_done_ready", 32'(in_ready), 32'd1);

        // overflow exception, held until ack, immune to flush
        send(OP_ADD, 16'h1234, 16'h0000, 1'b1, 1'b0, 4'd7, 1'b1, 16'h0040, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            chk("ovf_exc_valid", 32'(exc_valid), 32'd1);
            chk("ovf_exc_cause", 32'(exc_cause), 32'(EXC_OVF));
            chk("ovf_exc_pc",    32'(exc_pc),    32'h0040);
            chk("ovf_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        flush   = 1'b0;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("ovf_ack_valid", 32'(exc_valid), 32'd0);
        chk("ovf_ack_cause", 32'(exc_cause), 32'd0);
        chk("ovf_ack_ready", 32'(in_ready),  32'd1);

        // divide by zero takes priority over overflow; ack together with flush
        send(OP_DIV, 16'hFFFF, 16'h0009, 1'b1, 1'b1, 4'd4, 1'b1, 16'h0080, 1'b0, 1'b1);
        chk("div0_exc_valid", 32'(exc_valid), 32'd1);
        chk("div0_exc_cause", 32'(exc_cause), 32'(EXC_DIV0));
        chk("div0_exc_pc",    32'(exc_pc),    32'h0080);
        exc_ack = 1'b1;
        flush   = 1'b1;
        tick();
        exc_ack = 1'b0;
        flush   = 1'b0;
        chk("div0_ack_valid", 32'(exc_valid), 32'd0);
        chk("div0_ack_ready", 32'(in_ready),  32'd1);

        // DIV whose R0 write is flushed, then a normal ADD
        send(OP_DIV, 16'h0007, 16'h0003, 1'b0, 1'b0, 4'd2, 1'b1, 16'h0090, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_wb2_we", 32'(rf_we), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_idle_ready", 32'(in_ready), 32'd1);
        send(OP_ADD, 16'h0066, 16'h0000, 1'b0, 1'b0, 4'd6, 1'b1, 16'h00A0, 1'b0, 1'b1);
        tick();

        // transfer presented with flush is dropped
        send(OP_ADD, 16'hDEAD, 16'h0000, 1'b0, 1'b0, 4'd9, 1'b1, 16'h00B0, 1'b1, 1'b1);
        tick();

        // dual op targeting R0: both writes land on address 0, second one last
        send(OP_MUL, 16'h1111, 16'h2222, 1'b0, 1'b0, 4'd0, 1'b1, 16'h00C0, 1'b0, 1'b1);
        tick();
        tick();

        // back-to-back single ops, then reset mid-sequence
        for (int i = 0; i < 6; i++) begin
            send(b2b_ops[i % 3], 16'h0100 + 16'(i), 16'h0000, 1'b0, 1'b0, 4'(i + 1), 1'b1,
                 16'h0200 + 16'(i * 2), 1'b0, 1'b1);
        end
        send(OP_MUL, 16'h0BAD, 16'h0BAD, 1'b0, 1'b0, 4'd8, 1'b0, 16'h0300, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        reset = 1'b1;
        tick();
        chk("midrst_release_ready", 32'(in_ready), 32'd1);

        // reset while an exception is held
        send(OP_SUB, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0400, 1'b0, 1'b1);
        chk("excrst_pre_valid", 32'(exc_valid), 32'd1);
        reset = 1'b0;
        tick();
        chk_reset_outputs("excrst");
        reset = 1'b1;
        repeat (3) tick();
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
